uart_rx_frame: RTL

//  Serial receiver for the COM link; the receive-side counterpart of the UART transmitter.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rx_bit_sampler.sv | 44 ++++
 rtl/uart_rx_frame.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS   = 8;
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/rx_bit_sampler.sv
// rx synchroniser plus optional 2-of-3 tick vote (enabled by RX_MAJORITY_EN).
// 'sample' is the value the receiver FSM acts on at each tick.
module rx_bit_sampler (
  input  logic clk,
  input  logic rst_n,
`ifdef RX_MAJORITY_EN
  input  logic tick,
`endif
  input  logic rx,
  output logic sample
);

  logic [1:0] sync;
  logic       rx_s;

  // Reset to the idle-high line level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

`ifdef RX_MAJORITY_EN
  logic [1:0] vote;

  // Two previous tick samples; together with the current rx_s they form the vote window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote <= 2'b11;
    end else if (tick) begin
      vote <= {vote[0], rx_s};
    end
  end

  assign sample = (vote[1] & vote[0]) | (vote[1] & rx_s) | (vote[0] & rx_s);
`else
  assign sample = rx_s;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, 8 data bits LSB first, parity, stop; one valid pulse per frame.
// Optional majority-vote sampling is selected with the RX_MAJORITY_EN macro.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 pbit, pbit_n;
  logic                 load;
  logic                 sample;

  rx_bit_sampler u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef RX_MAJORITY_EN
    .tick   (tick),
`endif
    .rx     (rx),
    .sample (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sh    <= '0;
      pbit  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      sh    <= sh_n;
      pbit  <= pbit_n;
    end
  end

  // Everything holds when tick is low; 'load' marks the stop-bit decision tick.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    sh_n    = sh;
    pbit_n  = pbit;
    load    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!sample) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            if (sample) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              cnt_n   = '0;
              bidx_n  = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            sh_n  = {sample, sh[DATA_BITS-1:1]};
            cnt_n = '0;
            if (bidx == LAST_BIT) begin
              state_n = PARITY;
            end else begin
              bidx_n = bidx + 3'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            pbit_n  = sample;
            cnt_n   = '0;
            state_n = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            load    = 1'b1;
            cnt_n   = '0;
            // Leaving at mid stop bit leaves half a bit to spot a back-to-back start.
            state_n = sample ? IDLE : BREAK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BREAK: begin
          if (sample) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        data       <= sh;
        parity_err <= (^sh) ^ pbit ^ PARITY_ODD;
        frame_err  <= ~sample;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
